// File: rtl/exe_stage_pipe_if.sv
// Handshake and datapath bundle between ID/EXE, the execute stage and MEM.
// The slave modport is the execute stage's view; master is the driving side.
interface exe_stage_pipe_if #(
  parameter int DW = 32,
  parameter int RW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    cmd;
  logic          s_en;
  logic          wb_en;
  logic          mem_rd;
  logic          mem_wr;
  logic [RW-1:0] dst;
  logic [DW-1:0] val1;
  logic [DW-1:0] val2;
  logic [DW-1:0] val_rm;
  logic [1:0]    fwd_sel1;
  logic [1:0]    fwd_sel2;
  logic [DW-1:0] fwd_mem;
  logic [DW-1:0] fwd_wb;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result_o;
  logic [DW-1:0] store_o;
  logic          wb_en_o;
  logic          mem_rd_o;
  logic          mem_wr_o;
  logic [RW-1:0] dst_o;
  logic [3:0]    sr_o;
  logic          busy;

  modport slave (
    input  in_valid, cmd, s_en, wb_en, mem_rd, mem_wr, dst, val1, val2, val_rm,
           fwd_sel1, fwd_sel2, fwd_mem, fwd_wb, out_ready,
    output in_ready, out_valid, result_o, store_o, wb_en_o, mem_rd_o, mem_wr_o,
           dst_o, sr_o, busy
  );

  modport master (
    output in_valid, cmd, s_en, wb_en, mem_rd, mem_wr, dst, val1, val2, val_rm,
           fwd_sel1, fwd_sel2, fwd_mem, fwd_wb, out_ready,
    input  in_ready, out_valid, result_o, store_o, wb_en_o, mem_rd_o, mem_wr_o,
           dst_o, sr_o, busy
  );
endinterface

// File: rtl/exe_stage_pipe.sv
// ARM execute stage: single-cycle ALU, iterative MUL, NZCV flags, EXE/MEM register
// with valid/ready. Define EXE_FWD_EN to route val1/val_rm through the forwarding muxes.
module exe_stage_pipe #(
  parameter int DW       = 32,
  parameter int RW       = 4,
  parameter int MUL_STEP = 1
) (
  input logic            clk,
  input logic            rst_n,
  exe_stage_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(DW / MUL_STEP + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DW / MUL_STEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  function automatic logic [DW-1:0] fwd_pick(input logic [1:0] sel, input logic [DW-1:0] id_v,
                                              input logic [DW-1:0] mem_v, input logic [DW-1:0] wb_v);
    case (sel)
      2'd1:    return mem_v;
      2'd2:    return wb_v;
      default: return id_v;
    endcase
  endfunction

  state_t        r_state;
  logic          r_out_valid;
  logic          r_busy;
  logic [DW-1:0] r_result;
  logic [DW-1:0] r_store;
  logic          r_wb_en;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic [RW-1:0] r_dst;
  logic [3:0]    r_sr;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_mcand;
  logic [DW-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic          r_p_s_en;
  logic          r_p_wb_en;
  logic          r_p_mem_rd;
  logic          r_p_mem_wr;
  logic [RW-1:0] r_p_dst;
  logic [DW-1:0] r_p_store;

  logic          w_in_ready;
  logic          w_accept;
  logic [DW-1:0] w_op1;
  logic [DW-1:0] w_store;
  logic [DW:0]   w_ext;
  logic [DW-1:0] w_alu_res;
  logic          w_alu_c;
  logic          w_alu_v;
  logic [DW-1:0] w_acc_nxt;

`ifdef EXE_FWD_EN
  assign w_op1   = fwd_pick(bus.fwd_sel1, bus.val1, bus.fwd_mem, bus.fwd_wb);
  assign w_store = fwd_pick(bus.fwd_sel2, bus.val_rm, bus.fwd_mem, bus.fwd_wb);
`else
  logic w_unused_fwd;
  assign w_op1        = bus.val1;
  assign w_store      = bus.val_rm;
  assign w_unused_fwd = ^{bus.fwd_sel1, bus.fwd_sel2, bus.fwd_mem, bus.fwd_wb};
`endif

  assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // Single-cycle ALU at DW+1 bits; C/V default to the current status so
  // logical ops and undefined commands preserve them.
  always_comb begin
    w_ext     = '0;
    w_alu_res = '0;
    w_alu_c   = r_sr[1];
    w_alu_v   = r_sr[0];
    case (bus.cmd)
      CMD_MOV: w_alu_res = bus.val2;
      CMD_MVN: w_alu_res = ~bus.val2;
      CMD_ADD, CMD_ADC: begin
        w_ext = {1'b0, w_op1} + {1'b0, bus.val2}
              + {{DW{1'b0}}, (bus.cmd == CMD_ADC) ? r_sr[1] : 1'b0};
        w_alu_res = w_ext[DW-1:0];
        w_alu_c   = w_ext[DW];
        w_alu_v   = (w_op1[DW-1] == bus.val2[DW-1]) && (w_alu_res[DW-1] != w_op1[DW-1]);
      end
      CMD_SUB, CMD_SBC: begin
        w_ext = {1'b0, w_op1} - {1'b0, bus.val2}
              - {{DW{1'b0}}, (bus.cmd == CMD_SBC) ? ~r_sr[1] : 1'b0};
        w_alu_res = w_ext[DW-1:0];
        w_alu_c   = ~w_ext[DW];
        w_alu_v   = (w_op1[DW-1] != bus.val2[DW-1]) && (w_alu_res[DW-1] != w_op1[DW-1]);
      end
      CMD_AND: w_alu_res = w_op1 & bus.val2;
      CMD_ORR: w_alu_res = w_op1 | bus.val2;
      CMD_EOR: w_alu_res = w_op1 ^ bus.val2;
      default: w_alu_res = '0;
    endcase
  end

  // One multiplier iteration: fold MUL_STEP partial products into the accumulator.
  always_comb begin
    w_acc_nxt = r_acc;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (r_mplier[k]) begin
        w_acc_nxt = w_acc_nxt + (r_mcand << k);
      end else begin
        w_acc_nxt = w_acc_nxt;
      end
    end
  end

  // Stage FSM, multiplier state and EXE/MEM result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_store     <= '0;
      r_wb_en     <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_dst       <= '0;
      r_sr        <= 4'b0000;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_p_s_en    <= 1'b0;
      r_p_wb_en   <= 1'b0;
      r_p_mem_rd  <= 1'b0;
      r_p_mem_wr  <= 1'b0;
      r_p_dst     <= '0;
      r_p_store   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && (bus.cmd == CMD_MUL)) begin
            r_state     <= S_MUL;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_mcand     <= w_op1;
            r_mplier    <= bus.val2;
            r_cnt       <= CNT_INIT;
            r_p_s_en    <= bus.s_en;
            r_p_wb_en   <= bus.wb_en;
            r_p_mem_rd  <= bus.mem_rd;
            r_p_mem_wr  <= bus.mem_wr;
            r_p_dst     <= bus.dst;
            r_p_store   <= w_store;
          end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu_res;
            r_store     <= w_store;
            r_wb_en     <= bus.wb_en;
            r_mem_rd    <= bus.mem_rd;
            r_mem_wr    <= bus.mem_wr;
            r_dst       <= bus.dst;
            if (bus.s_en) begin
              r_sr <= {w_alu_res[DW-1], ~|w_alu_res, w_alu_c, w_alu_v};
            end
          end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end else begin
            r_out_valid <= r_out_valid;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << MUL_STEP;
          r_mplier <= r_mplier >> MUL_STEP;
          r_cnt    <= r_cnt - CNT_LAST;
          if (r_cnt == CNT_LAST) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_result    <= w_acc_nxt;
            r_store     <= r_p_store;
            r_wb_en     <= r_p_wb_en;
            r_mem_rd    <= r_p_mem_rd;
            r_mem_wr    <= r_p_mem_wr;
            r_dst       <= r_p_dst;
            if (r_p_s_en) begin
              r_sr <= {w_acc_nxt[DW-1], ~|w_acc_nxt, r_sr[1:0]};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result_o  = r_result;
  assign bus.store_o   = r_store;
  assign bus.wb_en_o   = r_wb_en;
  assign bus.mem_rd_o  = r_mem_rd;
  assign bus.mem_wr_o  = r_mem_wr;
  assign bus.dst_o     = r_dst;
  assign bus.sr_o      = r_sr;
  assign bus.busy      = r_busy;
endmodule
